bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one downstream memory bus between the core's two requesters: the fetch port and the mem port.
- Each requester issues single-cycle request pulses and receives single-cycle response pulses.
- The arbiter captures each request, serialises transactions onto the bus (one outstanding at a time) and routes each response back to its owner.
- Sits between the core's fetch/mem bus ports and the memory/MMIO interconnect.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- f_req_enable  input  1  fetch request pulse
- f_mode  input  1  fetch mode (0 read, 1 write)
- f_addr  input  ADDR_WIDTH  fetch address
- f_wdata  input  DATA_WIDTH  fetch write data
- f_wstrb  input  DATA_WIDTH/8  fetch byte strobe
- f_resp_enable  output  1  fetch response pulse
- f_resp_data  output  DATA_WIDTH  fetch read data
- m_req_enable, m_mode, m_addr, m_wdata, m_wstrb  input  as fetch  mem-stage request
- m_resp_enable, m_resp_data  output  as fetch  mem-stage response
- bus_req_enable  output  1  downstream request pulse
- bus_mode  output  1  downstream mode
- bus_addr  output  ADDR_WIDTH  downstream address
- bus_wdata  output  DATA_WIDTH  downstream write data
- bus_wstrb  output  DATA_WIDTH/8  downstream strobe
- bus_resp_enable  input  1  downstream response pulse
- bus_resp_data  input  DATA_WIDTH  downstream read data
- protocol_error  output  1  sticky violation flag

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; both slots empty; state IDLE; round-robin pointer favours mem.
- Capture: a req_enable pulse at edge N latches mode/addr/wdata/wstrb into that requester's slot and sets pending.
  - A pulse while the own slot is pending or in flight is dropped and sets protocol_error (sticky until rst).
- FSM IDLE:
  - If any slot is pending at an edge: select a winner, register its payload onto bus_*, assert bus_req_enable for exactly one cycle, and go to BUSY.
  - Net effect: a request captured at edge N reaches the bus on edge N+1 at earliest.
  - A bus_resp_enable seen in IDLE is ignored.
- FSM BUSY:
  - bus_req_enable is deasserted; bus_addr/mode/wdata/wstrb hold their values.
  - On bus_resp_enable at edge M: register bus_resp_data into the owner's resp_data, pulse the owner's resp_enable for one cycle (visible after M), clear the owner's slot, and return to IDLE.
  - The next grant can occur at edge M+1.
- Response data: resp_data holds its value until that owner's next response. The non-owner's resp outputs are untouched.
- Default arbitration: fixed priority, mem over fetch when both are pending.
- Simultaneous events:
  - A new pulse from the non-owner during BUSY or on the response edge is captured normally.
  - A pulse arriving at the same edge as the IDLE grant is not eligible until the next edge.
- No timeout: BUSY waits indefinitely.
- Reset mid-operation (rst in BUSY): abandons the transaction with no response pulse. A late bus_resp_enable after reset is ignored (arrives in IDLE).

Optional Feature:
- Macro: BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: a one-bit last-grant pointer is kept. When both slots are pending, the requester not granted last wins; the pointer updates on each grant.
- Undefined: fixed mem-over-fetch priority; no pointer register.

Decomposition:
- Package bus_pkg:
  - typedef bus_req_t struct {mode, addr, wdata, wstrb}
  - enum arb_state_t {ARB_IDLE, ARB_BUSY}
  - localparams REQ_FETCH=0, REQ_MEM=1
- Sub-module req_slot: capture register plus pending/in-flight flags and violation detect. Instantiated twice, once for fetch and once for mem.

Test Plan:
- Single fetch read: f_req_enable with addr 0x100 at edge 1 -> bus_req_enable for one cycle after edge 2 with bus_addr 0x100, mode 0. bus_resp_enable with data 0xDEADBEEF at edge 5 -> f_resp_enable one cycle after edge 5 with f_resp_data 0xDEADBEEF; m_resp_enable stays 0.
- Simultaneous pulses: fetch addr 0x0 and mem write addr 0x2000 (wdata 0x55, wstrb 0x1) at the same edge -> mem issued first. After mem's response, fetch issues at the next edge. With BUS_ARBITER_ROUND_ROBIN_EN and a prior mem grant -> fetch issued first.
- Back-to-back: fetch pulse arriving during a mem BUSY -> fetch issued on the edge after the mem response. Each response is delivered only to its owner, with correct data.
- Violation: second f_req_enable while a fetch is in flight -> dropped; protocol_error=1; in-flight transaction completes normally.
- Reset in BUSY: rst one cycle, then bus_resp_enable -> no resp pulses; all outputs 0; protocol_error=0; a subsequent new request works.
- Starvation check (round-robin build): both requesters re-request continuously for 8 transactions -> grants alternate mem/fetch strictly.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package bus_pkg;

    // Payload widths of the shared bus; bus_arbiter parameters default to these.
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_STRB_W = BUS_DATA_W / 8;

    // Requester identifiers, also used as the grant/owner encoding.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_MEM   = 1'b1;

    // One captured request.
    typedef struct packed {
        logic                  mode;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] wstrb;
    } bus_req_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Choose a winner among pending slots; prefer_mem breaks a tie.
    function automatic logic arb_pick(input logic f_pend, input logic m_pend,
                                      input logic prefer_mem);
        logic win;
        if (f_pend && m_pend) begin
            win = prefer_mem ? REQ_MEM : REQ_FETCH;
        end else if (m_pend) begin
            win = REQ_MEM;
        end else begin
            win = REQ_FETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter_req_slot.sv
// req_slot: holds one requester's captured request and tracks whether it is
// waiting for a grant (pending) or currently on the bus (in flight).
// A new pulse while the slot is occupied is dropped and flagged.
module req_slot
    import bus_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req_enable,
    input  bus_req_t req_in,
    input  logic     grant,
    input  logic     done,
    output logic     pending,
    output logic     in_flight,
    output bus_req_t payload,
    output logic     violation
);

    logic     pending_r;
    logic     in_flight_r;
    bus_req_t payload_r;
    logic     occupied_s;

    assign occupied_s = pending_r | in_flight_r;
    assign violation  = req_enable & occupied_s;
    assign pending    = pending_r;
    assign in_flight  = in_flight_r;
    assign payload    = payload_r;

    // Slot occupancy and payload capture; grant and capture never coincide
    // because a granted slot is occupied at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= 1'b0;
            in_flight_r <= 1'b0;
            payload_r   <= '0;
        end else begin
            if (grant) begin
                pending_r   <= 1'b0;
                in_flight_r <= 1'b1;
            end else if (done) begin
                in_flight_r <= 1'b0;
            end else begin
                in_flight_r <= in_flight_r;
            end
            if (req_enable && !occupied_s) begin
                pending_r <= 1'b1;
                payload_r <= req_in;
            end else begin
                payload_r <= payload_r;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises fetch and mem requests onto one downstream bus,
// one transaction outstanding at a time, and routes each response to its
// owner. Default tie-break is mem over fetch; defining
// BUS_ARBITER_ROUND_ROBIN_EN switches to alternating priority based on the
// last grant. The *_WIDTH parameters must match the bus_pkg widths.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_W,
    parameter int DATA_WIDTH = BUS_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    f_req_enable,
    input  logic                    f_mode,
    input  logic [ADDR_WIDTH-1:0]   f_addr,
    input  logic [DATA_WIDTH-1:0]   f_wdata,
    input  logic [DATA_WIDTH/8-1:0] f_wstrb,
    output logic                    f_resp_enable,
    output logic [DATA_WIDTH-1:0]   f_resp_data,
    input  logic                    m_req_enable,
    input  logic                    m_mode,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_resp_enable,
    output logic [DATA_WIDTH-1:0]   m_resp_data,
    output logic                    bus_req_enable,
    output logic                    bus_mode,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    input  logic                    bus_resp_enable,
    input  logic [DATA_WIDTH-1:0]   bus_resp_data,
    output logic                    protocol_error
);

    arb_state_t state_r, state_nxt_s;
    bus_req_t   f_in_s, m_in_s, f_pay_s, m_pay_s, win_pay_s, bus_pay_r;
    logic       f_pend_s, m_pend_s, f_fly_s, m_fly_s, f_viol_s, m_viol_s;
    logic       grant_f_s, grant_m_s, done_f_s, done_m_s;
    logic       winner_s, owner_r, prefer_mem_s;
    logic       bus_req_r, f_resp_en_r, m_resp_en_r, perr_r;
    logic [DATA_WIDTH-1:0] f_resp_data_r, m_resp_data_r;

    assign f_in_s = '{mode: f_mode, addr: f_addr, wdata: f_wdata, wstrb: f_wstrb};
    assign m_in_s = '{mode: m_mode, addr: m_addr, wdata: m_wdata, wstrb: m_wstrb};

    req_slot u_fetch_slot (
        .clk(clk), .rst(rst), .req_enable(f_req_enable), .req_in(f_in_s),
        .grant(grant_f_s), .done(done_f_s), .pending(f_pend_s),
        .in_flight(f_fly_s), .payload(f_pay_s), .violation(f_viol_s)
    );

    req_slot u_mem_slot (
        .clk(clk), .rst(rst), .req_enable(m_req_enable), .req_in(m_in_s),
        .grant(grant_m_s), .done(done_m_s), .pending(m_pend_s),
        .in_flight(m_fly_s), .payload(m_pay_s), .violation(m_viol_s)
    );

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic last_grant_r;

    // Last-grant pointer; starts at fetch so the first tie goes to mem.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_FETCH;
        end else if (grant_f_s || grant_m_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign prefer_mem_s = (last_grant_r == REQ_FETCH);
`else
    assign prefer_mem_s = 1'b1;
`endif

    // Next-state, grant and response-routing decisions.
    always_comb begin
        state_nxt_s = state_r;
        grant_f_s   = 1'b0;
        grant_m_s   = 1'b0;
        done_f_s    = 1'b0;
        done_m_s    = 1'b0;
        winner_s    = arb_pick(f_pend_s, m_pend_s, prefer_mem_s);
        win_pay_s   = (winner_s == REQ_MEM) ? m_pay_s : f_pay_s;
        case (state_r)
            ARB_IDLE: begin
                if (f_pend_s || m_pend_s) begin
                    grant_f_s   = (winner_s == REQ_FETCH);
                    grant_m_s   = (winner_s == REQ_MEM);
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (bus_resp_enable) begin
                    done_f_s    = (owner_r == REQ_FETCH) & f_fly_s;
                    done_m_s    = (owner_r == REQ_MEM) & m_fly_s;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State register, registered bus/response outputs and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ARB_IDLE;
            owner_r       <= REQ_FETCH;
            bus_req_r     <= 1'b0;
            bus_pay_r     <= '0;
            f_resp_en_r   <= 1'b0;
            m_resp_en_r   <= 1'b0;
            f_resp_data_r <= '0;
            m_resp_data_r <= '0;
            perr_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_req_r   <= grant_f_s | grant_m_s;
            f_resp_en_r <= done_f_s;
            m_resp_en_r <= done_m_s;
            perr_r      <= perr_r | f_viol_s | m_viol_s;
            if (grant_f_s || grant_m_s) begin
                bus_pay_r <= win_pay_s;
                owner_r   <= winner_s;
            end else begin
                bus_pay_r <= bus_pay_r;
                owner_r   <= owner_r;
            end
            if (done_f_s) begin
                f_resp_data_r <= bus_resp_data;
            end else begin
                f_resp_data_r <= f_resp_data_r;
            end
            if (done_m_s) begin
                m_resp_data_r <= bus_resp_data;
            end else begin
                m_resp_data_r <= m_resp_data_r;
            end
        end
    end

    assign bus_req_enable = bus_req_r;
    assign bus_mode       = bus_pay_r.mode;
    assign bus_addr       = bus_pay_r.addr;
    assign bus_wdata      = bus_pay_r.wdata;
    assign bus_wstrb      = bus_pay_r.wstrb;
    assign f_resp_enable  = f_resp_en_r;
    assign f_resp_data    = f_resp_data_r;
    assign m_resp_enable  = m_resp_en_r;
    assign m_resp_data    = m_resp_data_r;
    assign protocol_error = perr_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random
// traffic, all compared each cycle against a transaction-level model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req_enable = 1'b0, f_mode = 1'b0;
    logic [31:0] f_addr = 32'h0, f_wdata = 32'h0;
    logic [3:0]  f_wstrb = 4'h0;
    logic        m_req_enable = 1'b0, m_mode = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic [3:0]  m_wstrb = 4'h0;
    logic        bus_resp_enable = 1'b0;
    logic [31:0] bus_resp_data = 32'h0;
    logic        f_resp_enable, m_resp_enable, bus_req_enable, bus_mode, protocol_error;
    logic [31:0] f_resp_data, m_resp_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_enable(f_req_enable), .f_mode(f_mode), .f_addr(f_addr),
        .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_resp_enable(f_resp_enable), .f_resp_data(f_resp_data),
        .m_req_enable(m_req_enable), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_enable(m_resp_enable), .m_resp_data(m_resp_data),
        .bus_req_enable(bus_req_enable), .bus_mode(bus_mode), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_resp_enable(bus_resp_enable), .bus_resp_data(bus_resp_data),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-requester waiting request, one in-flight owner.
    logic        md_pend[2];
    logic        md_mode[2];
    logic [31:0] md_addr[2], md_wdata[2];
    logic [3:0]  md_wstrb[2];
    logic        md_busy;
    int          md_owner, md_last;
    logic        exp_bus_req, exp_bus_mode, exp_f_en, exp_m_en, exp_perr;
    logic [31:0] exp_bus_addr, exp_bus_wdata, exp_f_data, exp_m_data;
    logic [3:0]  exp_bus_wstrb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md_pend[i] = 1'b0; md_mode[i] = 1'b0; md_addr[i] = 32'h0;
            md_wdata[i] = 32'h0; md_wstrb[i] = 4'h0;
        end
        md_busy = 1'b0; md_owner = 0; md_last = 0;
        exp_bus_req = 1'b0; exp_bus_mode = 1'b0; exp_bus_addr = 32'h0;
        exp_bus_wdata = 32'h0; exp_bus_wstrb = 4'h0;
        exp_f_en = 1'b0; exp_m_en = 1'b0; exp_f_data = 32'h0; exp_m_data = 32'h0;
        exp_perr = 1'b0;
    endtask

    task automatic model_step();
        logic occ[2];
        int   w;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) occ[i] = md_pend[i] || (md_busy && md_owner == i);
            exp_bus_req = 1'b0; exp_f_en = 1'b0; exp_m_en = 1'b0;
            if (!md_busy && (md_pend[0] || md_pend[1])) begin
                if (md_pend[0] && md_pend[1]) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                    w = (md_last == 1) ? 0 : 1;
`else
                    w = 1;
`endif
                end else begin
                    w = md_pend[1] ? 1 : 0;
                end
                exp_bus_req = 1'b1; exp_bus_mode = md_mode[w]; exp_bus_addr = md_addr[w];
                exp_bus_wdata = md_wdata[w]; exp_bus_wstrb = md_wstrb[w];
                md_busy = 1'b1; md_owner = w; md_pend[w] = 1'b0; md_last = w;
            end else if (md_busy && bus_resp_enable) begin
                if (md_owner == 0) begin exp_f_en = 1'b1; exp_f_data = bus_resp_data; end
                else begin exp_m_en = 1'b1; exp_m_data = bus_resp_data; end
                md_busy = 1'b0;
            end
            if (f_req_enable) begin
                if (occ[0]) exp_perr = 1'b1;
                else begin
                    md_pend[0] = 1'b1; md_mode[0] = f_mode; md_addr[0] = f_addr;
                    md_wdata[0] = f_wdata; md_wstrb[0] = f_wstrb;
                end
            end
            if (m_req_enable) begin
                if (occ[1]) exp_perr = 1'b1;
                else begin
                    md_pend[1] = 1'b1; md_mode[1] = m_mode; md_addr[1] = m_addr;
                    md_wdata[1] = m_wdata; md_wstrb[1] = m_wstrb;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("bus_req_enable", bus_req_enable, exp_bus_req);
        check("bus_mode", bus_mode, exp_bus_mode);
        check("bus_addr", bus_addr, exp_bus_addr);
        check("bus_wdata", bus_wdata, exp_bus_wdata);
        check("bus_wstrb", bus_wstrb, exp_bus_wstrb);
        check("f_resp_enable", f_resp_enable, exp_f_en);
        check("f_resp_data", f_resp_data, exp_f_data);
        check("m_resp_enable", m_resp_enable, exp_m_en);
        check("m_resp_data", m_resp_data, exp_m_data);
        check("protocol_error", protocol_error, exp_perr);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // then all pulse inputs are released.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        rst = 1'b0; f_req_enable = 1'b0; m_req_enable = 1'b0; bus_resp_enable = 1'b0;
    endtask

    task automatic fetch_req(input logic md, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        f_req_enable = 1'b1; f_mode = md; f_addr = a; f_wdata = d; f_wstrb = s;
    endtask

    task automatic mem_req(input logic md, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_req_enable = 1'b1; m_mode = md; m_addr = a; m_wdata = d; m_wstrb = s;
    endtask

    task automatic respond(input logic [31:0] d);
        bus_resp_enable = 1'b1; bus_resp_data = d;
    endtask

    logic [31:0] first_addr, second_addr;
    logic [31:0] grant_addrs[$];
    int          cyc;

    initial begin
        model_reset();
        // Reset state.
        rst = 1'b1; step();
        rst = 1'b1; step();

        // Single fetch read.
        fetch_req(1'b0, 32'h100, 32'h0, 4'h0); step();
        step();
        check("t1_bus_req", bus_req_enable, 1'b1);
        check("t1_bus_addr", bus_addr, 32'h100);
        step();
        check("t1_req_one_cycle", bus_req_enable, 1'b0);
        step();
        respond(32'hDEADBEEF); step();
        check("t1_f_resp_en", f_resp_enable, 1'b1);
        check("t1_f_resp_data", f_resp_data, 32'hDEADBEEF);
        check("t1_m_resp_en", m_resp_enable, 1'b0);
        step();

        // Prior mem grant, then simultaneous fetch/mem pulses.
        mem_req(1'b0, 32'h3000, 32'h0, 4'h0); step();
        step();
        respond(32'h1111); step();
        fetch_req(1'b0, 32'h0, 32'h0, 4'h0);
        mem_req(1'b1, 32'h2000, 32'h55, 4'h1); step();
        step();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        first_addr = 32'h0; second_addr = 32'h2000;
`else
        first_addr = 32'h2000; second_addr = 32'h0;
`endif
        check("t2_first_addr", bus_addr, first_addr);
        step();
        respond(32'h2222); step();
        step();
        check("t2_second_req", bus_req_enable, 1'b1);
        check("t2_second_addr", bus_addr, second_addr);
        respond(32'h3333); step();
        step();

        // Back-to-back: fetch arrives while mem is busy.
        mem_req(1'b0, 32'h700, 32'h0, 4'h0); step();
        step();
        fetch_req(1'b1, 32'h800, 32'hCAFE, 4'hF); step();
        respond(32'hAAAA); step();
        check("t3_m_resp_data", m_resp_data, 32'hAAAA);
        check("t3_f_no_resp", f_resp_enable, 1'b0);
        step();
        check("t3_fetch_issue", bus_addr, 32'h800);
        respond(32'hBBBB); step();
        check("t3_f_resp_data", f_resp_data, 32'hBBBB);
        check("t3_m_data_held", m_resp_data, 32'hAAAA);
        step();

        // Protocol violation while fetch in flight.
        fetch_req(1'b0, 32'h500, 32'h0, 4'h0); step();
        step();
        fetch_req(1'b0, 32'h600, 32'h0, 4'h0); step();
        check("t4_perr", protocol_error, 1'b1);
        respond(32'h1234); step();
        check("t4_f_resp_data", f_resp_data, 32'h1234);
        step();
        check("t4_dropped", bus_req_enable, 1'b0);

        // Reset in BUSY, then a late response.
        fetch_req(1'b0, 32'h40, 32'h0, 4'h0); step();
        step();
        rst = 1'b1; step();
        check("t5_perr_cleared", protocol_error, 1'b0);
        respond(32'h9999); step();
        check("t5_no_resp", f_resp_enable, 1'b0);
        fetch_req(1'b0, 32'h80, 32'h0, 4'h0); step();
        step();
        check("t5_new_req", bus_addr, 32'h80);
        respond(32'h7777); step();
        step();

        // Continuous re-requests: grants must alternate.
        fetch_req(1'b0, 32'hF000, 32'h0, 4'h0);
        mem_req(1'b0, 32'hA000, 32'h0, 4'h0);
        cyc = 0;
        while (grant_addrs.size() < 8 && cyc < 200) begin
            step();
            cyc++;
            if (bus_req_enable) grant_addrs.push_back(bus_addr);
            if (exp_f_en) fetch_req(1'b0, 32'hF000, 32'h0, 4'h0);
            if (exp_m_en) mem_req(1'b0, 32'hA000, 32'h0, 4'h0);
            if (md_busy && !exp_bus_req) respond($urandom);
        end
        check("t6_grant_count", grant_addrs.size(), 8);
        for (int k = 1; k < grant_addrs.size(); k++)
            check("t6_alternate", grant_addrs[k] == grant_addrs[k-1], 1'b0);
        while (md_busy && cyc < 400) begin
            respond($urandom); step(); cyc++;
        end
        step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(3) == 0)
                fetch_req(1'($urandom), $urandom, $urandom, 4'($urandom));
            if ($urandom_range(3) == 0)
                mem_req(1'($urandom), $urandom, $urandom, 4'($urandom));
            if ($urandom_range(2) == 0) respond($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
